// File: rtl/issue_split_ctrl_if.sv
// Bundle-side and decode-side signals of the issue split controller.
// The slave modport is the controller's view; master is the surrounding pipeline's view.
interface issue_split_ctrl_if #(
   parameter int unsigned LANES = 2
);
   localparam int unsigned OW = (LANES > 1) ? $clog2(LANES) : 1;

   logic                  flush_i;
   logic                  bundle_valid_i;
   logic                  bundle_ready_o;
   logic [32*LANES-1:0]   instr_i;
   logic [LANES-1:0]      use_rs1_i;
   logic [LANES-1:0]      use_rs2_i;
   logic [OW-1:0]         oldest_i;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic [32*LANES-1:0]   instr_o;
   logic [LANES-1:0]      lane_valid_o;
   logic [7:0]            split_cnt_o;

   modport slave (
      input  flush_i, bundle_valid_i, instr_i, use_rs1_i, use_rs2_i, oldest_i, out_ready_i,
      output bundle_ready_o, out_valid_o, instr_o, lane_valid_o, split_cnt_o
   );

   modport master (
      output flush_i, bundle_valid_i, instr_i, use_rs1_i, use_rs2_i, oldest_i, out_ready_i,
      input  bundle_ready_o, out_valid_o, instr_o, lane_valid_o, split_cnt_o
   );
endinterface

// File: rtl/issue_split_ctrl.sv
// Splits an issue bundle into dependency-free beats in program order, holding the
// bundle and its pending-lane mask until every lane has been issued.
module issue_split_ctrl #(
   parameter int unsigned LANES      = 2,
   parameter bit          ENABLE_WAW = 1'b1
) (
   input logic               clk_i,
   input logic               rst_i,
   issue_split_ctrl_if.slave bus
);
   localparam int unsigned OW = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic {IDLE, SPLIT} state_t;

   state_t              state_q, state_d;
   logic [LANES-1:0]    pending_q, pending_d;
   logic [32*LANES-1:0] hold_instr_q;
   logic [LANES-1:0]    hold_rs1_q, hold_rs2_q;
   logic [OW-1:0]       hold_old_q;
   logic                out_valid_q;
   logic [LANES-1:0]    lane_valid_q;
   logic [32*LANES-1:0] instr_q;
   logic [7:0]          cnt_q;

   logic                advance, bundle_ready, accept, load, capture;
   logic [32*LANES-1:0] src_instr, grp_instr;
   logic [LANES-1:0]    src_rs1, src_rs2, src_mask, grp;
   logic [OW-1:0]       src_old;
   logic [31:0]         ins [LANES];

   function automatic logic writes_rd(input logic [31:0] x);
      return (x[6:0] != 7'b1100011) && (x[6:0] != 7'b0100011) && (x[11:7] != 5'd0);
   endfunction

   function automatic logic depends(input logic [31:0] older, input logic [31:0] younger,
                                    input logic rs1, input logic rs2);
      logic [4:0] rd;
      rd = older[11:7];
      return writes_rd(older) &&
             ((rs1 && (rd == younger[19:15])) || (rs2 && (rd == younger[24:20])) ||
              (ENABLE_WAW && writes_rd(younger) && (rd == younger[11:7])));
   endfunction

   assign advance      = !out_valid_q || bus.out_ready_i;
   assign bundle_ready = (state_q == IDLE) && advance && !bus.flush_i && !rst_i;
   assign accept       = bundle_ready && bus.bundle_valid_i;

   // A held bundle is served purely from the hold registers, never the live inputs.
   assign src_instr = (state_q == SPLIT) ? hold_instr_q : bus.instr_i;
   assign src_rs1   = (state_q == SPLIT) ? hold_rs1_q   : bus.use_rs1_i;
   assign src_rs2   = (state_q == SPLIT) ? hold_rs2_q   : bus.use_rs2_i;
   assign src_old   = (state_q == SPLIT) ? hold_old_q   : bus.oldest_i;
   assign src_mask  = (state_q == SPLIT) ? pending_q    : '1;

   // Walk lanes by age; the first pending lane that conflicts with the group closes it.
   always_comb begin : grp_sel
      logic stop;
      stop = 1'b0;
      grp  = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         ins[l] = src_instr[32*l +: 32];
      end
      for (int unsigned p = 0; p < LANES; p++) begin
         for (int unsigned l = 0; l < LANES; l++) begin
            if ((((l + LANES - 32'(src_old)) % LANES) == p) && src_mask[l] && !stop) begin
               for (int unsigned m = 0; m < LANES; m++) begin
                  if (grp[m] && depends(ins[m], ins[l], src_rs1[l], src_rs2[l])) stop = 1'b1;
               end
               if (!stop) grp[l] = 1'b1;
            end
         end
      end
      grp_instr = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         if (grp[l]) grp_instr[32*l +: 32] = ins[l];
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      load      = 1'b0;
      capture   = 1'b0;
      if (bus.flush_i) begin
         state_d   = IDLE;
         pending_d = '0;
      end else begin
         unique case (state_q)
            IDLE: if (accept) begin
               load = 1'b1;
               if (|(~grp)) begin
                  capture   = 1'b1;
                  pending_d = ~grp;
                  state_d   = SPLIT;
               end
            end
            SPLIT: if (advance) begin
               load      = 1'b1;
               pending_d = pending_q & ~grp;
               if ((pending_q & ~grp) == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q  <= 1'b0;
         lane_valid_q <= '0;
         instr_q      <= '0;
         cnt_q        <= '0;
         hold_instr_q <= '0;
         hold_rs1_q   <= '0;
         hold_rs2_q   <= '0;
         hold_old_q   <= '0;
      end else begin
         if (bus.flush_i) begin
            out_valid_q  <= 1'b0;
            lane_valid_q <= '0;
         end else if (load) begin
            out_valid_q  <= 1'b1;
            lane_valid_q <= grp;
            instr_q      <= grp_instr;
         end else if (advance) begin
            out_valid_q  <= 1'b0;
         end
         if (capture) begin
            hold_instr_q <= bus.instr_i;
            hold_rs1_q   <= bus.use_rs1_i;
            hold_rs2_q   <= bus.use_rs2_i;
            hold_old_q   <= bus.oldest_i;
            if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
         end
      end
   end

   assign bus.bundle_ready_o = bundle_ready;
   assign bus.out_valid_o    = out_valid_q;
   assign bus.instr_o        = instr_q;
   assign bus.lane_valid_o   = lane_valid_q;
   assign bus.split_cnt_o    = cnt_q;
endmodule

// File: doc/issue_split_ctrl.md
ISSUE_SPLIT_CTRL -- requirements
Module: issue_split_ctrl

Interface
REQ-001 Parameter LANES, default 2, number of issue lanes in a bundle (legal 2..4).
REQ-002 Parameter ENABLE_WAW, default 1, enables splitting on intra-bundle WAW (0 = RAW only).
REQ-003 clk_i  input  1  single clock, all state updates on rising edge.
REQ-004 rst_i  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 flush_i  input  1  synchronous pipeline flush (branch redirect).
REQ-006 bundle_valid_i  input  1  fetch/issue bundle present.
REQ-007 bundle_ready_o  output  1  bundle accepted this cycle when high with bundle_valid_i (inverse = upstream/PC stall).
REQ-008 instr_i  input  32*LANES  lane k at bits [32k+31:32k].
REQ-009 use_rs1_i / use_rs2_i  input  LANES each  lane k reads rs1/rs2.
REQ-010 oldest_i  input  max(1,$clog2(LANES))  index of oldest lane; program order is oldest_i, oldest_i+1, ... mod LANES.
REQ-011 out_valid_o  output  1  output bundle valid to decode.
REQ-012 out_ready_i  input  1  decode can take output bundle.
REQ-013 instr_o  output  32*LANES  issued instructions, same lane positions as instr_i.
REQ-014 lane_valid_o  output  LANES  1 = real instruction in lane, 0 = nop (lane instr_o = 32'h0).
REQ-015 split_cnt_o  output  8  count of bundles that needed more than one beat.

Function
REQ-016 writes_rd(x) SHALL be true iff opcode x[6:0] is not 1100011 and not 0100011 and x[11:7] != 0.
REQ-017 Younger lane j SHALL depend on older lane i iff writes_rd(i) and (rd_i==rs1_j & use_rs1_j, or rd_i==rs2_j & use_rs2_j, or ENABLE_WAW & writes_rd(j) & rd_i==rd_j).
REQ-018 Beat group SHALL be the longest program-order prefix of pending lanes with no dependency between any two members; group always contains at least the oldest pending lane.
REQ-019 States: IDLE (no held bundle), SPLIT (held bundle with nonempty pending mask).
REQ-020 advance = !out_valid_o | out_ready_i; output register loads only when advance.
REQ-021 bundle_ready_o SHALL be 1 iff state==IDLE and advance and !flush_i.
REQ-022 On accept: output register gets group lanes (others 32'h0, lane_valid 0), out_valid_o=1 next cycle (latency 1); if lanes remain, bundle, oldest_i and remaining mask are captured in hold registers and state -> SPLIT, else stay IDLE.
REQ-023 In SPLIT with advance: next group computed from hold registers only, loaded to output, removed from pending; pending empty -> IDLE next cycle.
REQ-024 IDLE, no accept, out_ready_i=1: out_valid_o SHALL drop to 0 next cycle.
REQ-025 out_valid_o=1 and out_ready_i=0: instr_o, lane_valid_o, state, pending SHALL hold stable.
REQ-026 split_cnt_o SHALL increment by 1 on each accept whose bundle leaves lanes pending; saturate at 255.
REQ-027 Fully serial bundle (each lane depends on previous) SHALL produce exactly LANES beats; bundle_ready_o low for LANES-1 advancing cycles.
REQ-028 flush_i SHALL, next cycle, clear out_valid_o, lane_valid_o, pending, state->IDLE; flush wins over accept and advance in the same cycle; split_cnt_o unaffected.

Reset
REQ-029 rst_i high at edge SHALL set state IDLE, pending 0, out_valid_o 0, lane_valid_o 0, instr_o 0, split_cnt_o 0; bundle_ready_o 0 while rst_i high.
REQ-030 rst_i SHALL take priority over flush_i and all handshakes, including mid-SPLIT.

Verification (LANES=2 unless stated)
REQ-031 instr_i={0x00700113,0x00500093}, oldest_i=0, out_ready_i=1 -> one beat, lane_valid_o=2'b11, bundle_ready_o stays 1, split_cnt_o=0.
REQ-032 lane0=0x00500093 (x1), lane1=0x002081B3 (add x3,x1,x2, use_rs1/rs2=1), oldest_i=0 -> beat1 lane_valid_o=01, lane1 instr_o=0; beat2 lane_valid_o=10; bundle_ready_o low one cycle; split_cnt_o=1.
REQ-033 Same but lanes swapped, oldest_i=1 -> beat1 lane_valid_o=10, beat2 01.
REQ-034 lane0=0x0020A223 (sw, rd field x4), lane1 reads x4 -> no split, 2'b11; ENABLE_WAW=0 with both lanes writing x1 -> no split; ENABLE_WAW=1 -> split.
REQ-035 During REQ-032 split hold out_ready_i=0 3 cycles -> beat1 stable; then flush_i=1 -> out_valid_o=0, bundle_ready_o=1 next cycle, beat2 never issued.
REQ-036 LANES=4, chain x1->x2->x3->x4 -> 4 beats, lane_valid_o 0001,0010,0100,1000; split_cnt_o at 255 saturates on further split.
